// File: rtl/apb_timer_bank.sv
// apb_timer_bank: multi-channel APB timer with prescalers, one-shot/periodic modes,
// channel cascading and a synchronous-start register.
module apb_timer_bank #(
  parameter int unsigned NumTimers    = 4,
  parameter int unsigned CntWidth     = 32,
  parameter int unsigned PrescWidth   = 8,
  parameter int unsigned ApbAddrWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [ApbAddrWidth-1:0] paddr_i,
  input  logic [31:0]             pwdata_i,
  output logic [31:0]             prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic [NumTimers-1:0]    irq_o
);
  localparam logic [10:0] WinEnd = 11'(16 * NumTimers);
  logic [9:0] addr;
  logic [4:0] ch;
  logic [1:0] rsel;
  logic access, addr_err, wr, is_start, unused_bits;
  logic [31:0] rdata;
  logic [NumTimers-1:0] en_q, en_d, os_q, os_d, ie_q, ie_d, cs_q, cs_d, match_q, match_d;
  logic [PrescWidth-1:0] presc_q [NumTimers];
  logic [PrescWidth-1:0] presc_d [NumTimers];
  logic [PrescWidth-1:0] pc_q [NumTimers];
  logic [PrescWidth-1:0] pc_d [NumTimers];
  logic [CntWidth-1:0] cnt_q [NumTimers];
  logic [CntWidth-1:0] cnt_d [NumTimers];
  logic [CntWidth-1:0] cmp_q [NumTimers];
  logic [CntWidth-1:0] cmp_d [NumTimers];
  assign addr        = paddr_i[9:0];
  assign ch          = addr[8:4];
  assign rsel        = addr[3:2];
  assign access      = psel_i & penable_i;
  assign is_start    = addr == 10'h200;
  assign addr_err    = (addr[1:0] != 2'b00) || (addr > 10'h200) || (!addr[9] && {1'b0, addr} >= WinEnd);
  assign wr          = access & pwrite_i & ~addr_err;
  assign pready_o    = 1'b1;
  assign pslverr_o   = access & addr_err;
  assign irq_o       = match_q & ie_q;
  assign unused_bits = ^{paddr_i, pwdata_i};
  // Channels are evaluated in order so a match ripples down a cascade chain in the same cycle.
  always_comb begin
    logic sel, ctrl_wr, start_set, tick, ev, prev;
    sel = 1'b0;
    ctrl_wr = 1'b0;
    start_set = 1'b0;
    tick = 1'b0;
    ev = 1'b0;
    prev = 1'b0;
    en_d = en_q;
    os_d = os_q;
    ie_d = ie_q;
    cs_d = cs_q;
    match_d = match_q;
    presc_d = presc_q;
    pc_d = pc_q;
    cnt_d = cnt_q;
    cmp_d = cmp_q;
    for (int i = 0; i < NumTimers; i++) begin
      sel        = wr && !is_start && ch == 5'(i);
      ctrl_wr    = sel && rsel == 2'd0;
      start_set  = wr && is_start && pwdata_i[i];
      tick       = en_q[i] && (cs_q[i] ? prev : pc_q[i] == presc_q[i]);
      ev         = tick && cnt_q[i] == cmp_q[i];
      prev       = ev;
      en_d[i]    = ctrl_wr ? pwdata_i[0] : start_set ? 1'b1 : (ev && os_q[i]) ? 1'b0 : en_q[i];
      os_d[i]    = ctrl_wr ? pwdata_i[1] : os_q[i];
      ie_d[i]    = ctrl_wr ? pwdata_i[2] : ie_q[i];
      cs_d[i]    = ctrl_wr ? (pwdata_i[3] && i != 0) : cs_q[i];
      presc_d[i] = ctrl_wr ? pwdata_i[8 +: PrescWidth] : presc_q[i];
      pc_d[i]    = (ctrl_wr || start_set || !en_q[i] || cs_q[i] || tick) ? '0 : pc_q[i] + 1'b1;
      cnt_d[i]   = (sel && rsel == 2'd1) ? pwdata_i[CntWidth-1:0] : ev ? '0 : tick ? cnt_q[i] + 1'b1 : cnt_q[i];
      cmp_d[i]   = (sel && rsel == 2'd2) ? pwdata_i[CntWidth-1:0] : cmp_q[i];
      match_d[i] = ev || (match_q[i] && !(sel && rsel == 2'd3 && pwdata_i[0]));
    end
  end
  always_comb begin
    rdata = '0;
    if (is_start) rdata[NumTimers-1:0] = en_q;
    for (int i = 0; i < NumTimers; i++)
      rdata = (!is_start && ch == 5'(i)) ?
              (rsel == 2'd0 ? 32'({presc_q[i], 4'b0, cs_q[i], ie_q[i], os_q[i], en_q[i]}) :
               rsel == 2'd1 ? 32'(cnt_q[i]) :
               rsel == 2'd2 ? 32'(cmp_q[i]) : 32'({en_q[i], match_q[i]})) : rdata;
  end
  assign prdata_o = (access && !pwrite_i && !addr_err) ? rdata : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q    <= '0;
      os_q    <= '0;
      ie_q    <= '0;
      cs_q    <= '0;
      match_q <= '0;
      presc_q <= '{default: '0};
      pc_q    <= '{default: '0};
      cnt_q   <= '{default: '0};
      cmp_q   <= '{default: '0};
    end else begin
      en_q    <= en_d;
      os_q    <= os_d;
      ie_q    <= ie_d;
      cs_q    <= cs_d;
      match_q <= match_d;
      presc_q <= presc_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
    end
  end
endmodule

// File: doc/apb_timer_bank.md
# apb_timer_bank

Parametrised multi-channel APB timer, the next-generation peripheral timer for the Ariane SoC peripheral subsystem. It sits behind an `axi2apb_64_32` bridge and drives one level interrupt per channel into PLIC sources. Relative to the fixed two-channel timer it adds:
- configurable channel count and counter width;
- per-channel prescaler;
- one-shot or periodic mode;
- channel cascading;
- a global synchronous-start register.

## Interface
Parameters:
- `NumTimers`, 4: number of channels, 1..32.
- `CntWidth`, 32: counter/compare width, 1..32.
- `PrescWidth`, 8: prescaler field width, 1..16.
- `ApbAddrWidth`, 32: width of `paddr_i`.

Ports:
- `clk_i`  in  1  clock; one clock, all logic on rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `psel_i`, `penable_i`, `pwrite_i`  in  1 each  APB control.
- `paddr_i`  in  ApbAddrWidth  byte address; bits [9:0] decoded, upper bits ignored.
- `pwdata_i`  in  32  write data.
- `prdata_o`  out  32  read data.
- `pready_o`  out  1  always 1; zero wait states.
- `pslverr_o`  out  1  error response.
- `irq_o`  out  NumTimers  per-channel level interrupt.

## Operation
Register map:
- Channel i window at 0x10*i.
- CTRL (+0x0):
  - [0] EN.
  - [1] ONESHOT.
  - [2] IRQ_EN.
  - [3] CASCADE (ignored and reads 0 on channel 0).
  - [8 +: PrescWidth] PRESC.
- CNT (+0x4): counter, read/write.
- CMP (+0x8): compare value, read/write.
- STATUS (+0xC):
  - [0] MATCH, write-1-to-clear.
  - [1] RUN, read-only mirror of EN.
- START (0x200):
  - Write: bit i=1 sets EN of channel i and leaves other CTRL fields unchanged; 0 bits have no effect.
  - Read: returns the EN vector.

Decode rules:
- Unimplemented bits read 0; writes to them are ignored.
- CNT/CMP bits above CntWidth read 0.
- pslverr_o=1 in the access phase (psel&penable) for:
  - a channel index >= NumTimers;
  - addresses 0x200 < a or a in [0x10*NumTimers, 0x200);
  - paddr_i[1:0] != 0.
- An erroring access has no side effects and reads 0.
- prdata_o is combinational in a read access phase and 0 otherwise.

Per-channel counting:
- Tick source:
  - Non-cascade: prescaler counter pc increments each cycle while EN. A tick occurs when pc==PRESC, then pc<=0.
  - Cascade: tick = match event of channel i-1 in the same cycle.
- On a tick, if CNT==CMP (match event):
  - CNT<=0 and MATCH<=1;
  - if ONESHOT, EN<=0.
- On a tick without a match: CNT<=CNT+1, wrapping silently at 2^CntWidth-1 to 0 with no event.
- EN=0: no ticks, pc held at 0; CNT retains its value.
- irq_o[i] = MATCH & IRQ_EN, driven from registered state.

Collision priority in a single cycle:
- SW write to CNT beats the hardware increment or clear.
- SW write to CTRL/START setting EN beats the one-shot EN clear.
- A new match event beats a W1C clear of MATCH, so MATCH stays 1.
- Any write to CTRL, or a START bit=1, resets pc to 0.

## Timing
- Reset values: all registers, pc, irq_o and pslverr_o are 0; prdata_o is 0; pready_o is 1.
- Register writes take effect at the access-phase clock edge.
- With PRESC=0, CMP=N, CNT=0, and EN written at edge E0:
  - CNT becomes 1..N at edges E1..EN;
  - the match occurs at edge E(N+1), after which CNT=0, MATCH=1 and irq_o is high.
  - Periodic mode: the period is (N+1)(PRESC+1) cycles.
- Cascade: channel i increments at the same edge on which channel i-1 matches. There is no added latency along the chain.
- Reset asserted mid-count: everything clears immediately (asynchronous). Counting restarts only after SW re-enables the channel.

## Test plan
- Reset, then read every register: all read 0. irq_o=0. A read of 0x10*NumTimers gives pslverr_o=1 and prdata 0. A read of 0x201 gives pslverr_o=1.
- Ch0 periodic with CMP=4, PRESC=0, IRQ_EN=1: irq_o[0] rises 5 cycles after the EN write. After W1C STATUS, it rises again 5 cycles after the previous match.
- Ch1 one-shot with CMP=2, PRESC=3: MATCH after 12 cycles, then EN=0 and CNT stays 0. STATUS reads 0x1.
- Ch1 CASCADE=1 with ch0 CMP=1, ch1 CMP=2: ch1 matches on the 3rd ch0 match edge, i.e. 6 cycles after both are enabled.
- START write 0xF with all CMP=7: all four irq_o bits assert on the same cycle.
- Collisions:
  - W1C STATUS on the exact match edge: MATCH stays 1.
  - CNT write of 0x3 on a tick edge: CNT reads 0x3.
  - With CntWidth=8 and CMP=0x300 written: reads back 0x00.
